// File: rtl/color_history_fetch_pkg.sv
// -----------------------------------------------------------------------------
// color_history_fetch_pkg
// Shared constants and types for the colour-history read path that feeds the
// pink-marker corner detector.
//   H_ACTIVE / V_ACTIVE : active raster size (pixels per line, lines per frame)
//   ADDR_W              : history RAM address width (covers 640*480 entries)
//   HIST_W              : history bits stored per pixel
//   COORD_W             : width of the x / y raster coordinates
//   fetch_state_t       : raster fetch FSM states
// -----------------------------------------------------------------------------
package color_history_fetch_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int HIST_W   = 4;
  localparam int COORD_W  = 10;

  // Encoding is fixed so the state can be probed alongside the detector's
  // own debug taps without a lookup table.
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DONE    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/color_history_fetch_hist_align_pipe.sv
// -----------------------------------------------------------------------------
// hist_align_pipe
// Delay line that carries each accepted pixel (x, y, addr, Cb, Cr) alongside
// its outstanding history RAM read, so the pixel and its history leave
// together. RD_LAT shift stages are followed by a registered output stage,
// giving RD_LAT+1 cycles from load to out_valid.
//
// Because the RAM is read-first, a detector write-back that lands while a read
// to the same address is in flight would otherwise be lost. Every stage
// compares its address against the write-back port each cycle and, on a hit,
// latches the written value; the most recent hit always overrides older ones.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   load, load_*          : new pixel entering stage 0
//   ram_rd_data           : RAM data, valid while the entry is in the last
//                           shift stage
//   wb_we/wb_addr/wb_data : detector write-back port (forwarding source)
//   out_*                 : registered, aligned pixel + history
// -----------------------------------------------------------------------------
module hist_align_pipe #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = color_history_fetch_pkg::ADDR_W,
  parameter int HIST_W = color_history_fetch_pkg::HIST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [9:0]        load_x,
  input  logic [9:0]        load_y,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_cb,
  input  logic [7:0]        load_cr,
  input  logic [HIST_W-1:0] ram_rd_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [HIST_W-1:0] wb_data,
  output logic              out_valid,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_cb,
  output logic [7:0]        out_cr,
  output logic [HIST_W-1:0] out_history
);

  import color_history_fetch_pkg::*;

  logic [RD_LAT-1:0]  stage_valid;
  logic [RD_LAT-1:0]  stage_fwd;
  logic [RD_LAT-1:0]  stage_hit;
  logic [COORD_W-1:0] stage_x        [RD_LAT];
  logic [COORD_W-1:0] stage_y        [RD_LAT];
  logic [ADDR_W-1:0]  stage_addr     [RD_LAT];
  logic [7:0]         stage_cb       [RD_LAT];
  logic [7:0]         stage_cr       [RD_LAT];
  logic [HIST_W-1:0]  stage_fwd_data [RD_LAT];
  logic               load_hit;

  // Write-back collision detect for the entry being loaded and for every
  // occupied stage. Empty stages never match, so bubbles cannot pick up data.
  always_comb begin
    load_hit  = load && wb_we && (load_addr == wb_addr);
    stage_hit = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      stage_hit[i] = stage_valid[i] && wb_we && (stage_addr[i] == wb_addr);
    end
  end

  // Occupancy bits are the only pipeline state that needs clearing on reset;
  // the payload is ignored wherever its valid bit is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= load;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  // Payload shift. A hit in the current cycle replaces any earlier forwarded
  // value, which is what makes the latest write win.
  always_ff @(posedge clk) begin
    stage_x[0]        <= load_x;
    stage_y[0]        <= load_y;
    stage_addr[0]     <= load_addr;
    stage_cb[0]       <= load_cb;
    stage_cr[0]       <= load_cr;
    stage_fwd[0]      <= load_hit;
    stage_fwd_data[0] <= wb_data;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_x[i]        <= stage_x[i-1];
      stage_y[i]        <= stage_y[i-1];
      stage_addr[i]     <= stage_addr[i-1];
      stage_cb[i]       <= stage_cb[i-1];
      stage_cr[i]       <= stage_cr[i-1];
      stage_fwd[i]      <= stage_fwd[i-1] | stage_hit[i-1];
      stage_fwd_data[i] <= stage_hit[i-1] ? wb_data : stage_fwd_data[i-1];
    end
  end

  // Output stage: the last shift stage meets its RAM data here. A write that
  // collides in this very cycle still takes priority over an older forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_addr    <= '0;
      out_cb      <= '0;
      out_cr      <= '0;
      out_history <= '0;
    end else begin
      out_valid <= stage_valid[RD_LAT-1];
      if (stage_valid[RD_LAT-1]) begin
        out_x    <= stage_x[RD_LAT-1];
        out_y    <= stage_y[RD_LAT-1];
        out_addr <= stage_addr[RD_LAT-1];
        out_cb   <= stage_cb[RD_LAT-1];
        out_cr   <= stage_cr[RD_LAT-1];
        if (stage_hit[RD_LAT-1]) begin
          out_history <= wb_data;
        end else if (stage_fwd[RD_LAT-1]) begin
          out_history <= stage_fwd_data[RD_LAT-1];
        end else begin
          out_history <= ram_rd_data;
        end
      end
    end
  end

endmodule

// File: rtl/color_history_fetch.sv
// -----------------------------------------------------------------------------
// color_history_fetch
// Read-side companion to the pink-marker corner detector. Raster-scans the
// incoming pixel stream, issues one history RAM read per accepted pixel and
// hands the detector each pixel's Cb/Cr, position, address and (forwarded)
// history, aligned and registered, RD_LAT+1 cycles after acceptance.
//
// Parameters: H_ACTIVE, V_ACTIVE (raster size), RD_LAT (RAM read latency,
// 1..4), ADDR_W, HIST_W.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   VGA_VS                     : active-low vsync; falling edge starts a frame
//   pix_en, Cb_in, Cr_in       : incoming active pixel
//   ram_rd_addr / ram_rd_data  : history RAM read port
//   wb_we, wb_addr, wb_data    : detector write-back, used for forwarding
//   Cb, Cr, color_history,
//   color_valid, read_addr,
//   read_x, read_y             : aligned outputs to the detector
//   frame_start                : one-cycle pulse per vsync falling edge
//   overflow                   : sticky, pixels seen after frame completion
// -----------------------------------------------------------------------------
module color_history_fetch #(
  parameter int H_ACTIVE = color_history_fetch_pkg::H_ACTIVE,
  parameter int V_ACTIVE = color_history_fetch_pkg::V_ACTIVE,
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = color_history_fetch_pkg::ADDR_W,
  parameter int HIST_W   = color_history_fetch_pkg::HIST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              VGA_VS,
  input  logic              pix_en,
  input  logic [7:0]        Cb_in,
  input  logic [7:0]        Cr_in,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [HIST_W-1:0] ram_rd_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [HIST_W-1:0] wb_data,
  output logic [7:0]        Cb,
  output logic [7:0]        Cr,
  output logic [HIST_W-1:0] color_history,
  output logic              color_valid,
  output logic [ADDR_W-1:0] read_addr,
  output logic [9:0]        read_x,
  output logic [9:0]        read_y,
  output logic              frame_start,
  output logic              overflow
);

  import color_history_fetch_pkg::*;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  fetch_state_t state, next_state;

  logic               vs_prev;
  logic               frame_edge;
  logic               accept;
  logic               overflow_set;
  logic [COORD_W-1:0] x, y;
  logic [ADDR_W-1:0]  addr;
  logic [COORD_W-1:0] cur_x, cur_y, next_x, next_y;
  logic [ADDR_W-1:0]  cur_addr, next_addr;

  assign frame_edge = vs_prev & ~VGA_VS;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_VS;
    end else begin
      state <= next_state;
    end
  end

  // cur_* is the position the current pixel takes: a frame edge zeroes it in
  // the same cycle, so a pixel coinciding with the edge becomes (0,0) of the
  // new frame. The address is stepped alongside x/y rather than computed as
  // y*H_ACTIVE+x so no multiplier is needed.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    overflow_set = 1'b0;
    cur_x        = x;
    cur_y        = y;
    cur_addr     = addr;
    if (frame_edge) begin
      cur_x    = '0;
      cur_y    = '0;
      cur_addr = '0;
    end

    case (state)
      ACTIVE:  accept       = pix_en;
      DONE:    overflow_set = pix_en;
      default: ;
    endcase

    if (frame_edge) begin
      next_state   = ACTIVE;
      accept       = pix_en;
      overflow_set = 1'b0;
    end

    if (accept && (cur_x == X_LAST) && (cur_y == Y_LAST)) begin
      next_state = DONE;
    end

    next_x    = cur_x;
    next_y    = cur_y;
    next_addr = cur_addr;
    if (accept) begin
      if (cur_x == X_LAST) begin
        next_x = '0;
        next_y = cur_y + 1'b1;
      end else begin
        next_x = cur_x + 1'b1;
      end
      next_addr = cur_addr + 1'b1;
    end
  end

  // VS_prev resets high so a VS already low at release counts as an edge.
  // Overflow clears on any frame edge and otherwise only ever sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev     <= 1'b1;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      ram_rd_addr <= '0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      vs_prev     <= VGA_VS;
      x           <= next_x;
      y           <= next_y;
      addr        <= next_addr;
      frame_start <= frame_edge;
      if (accept) begin
        ram_rd_addr <= cur_addr;
      end
      if (frame_edge) begin
        overflow <= 1'b0;
      end else if (overflow_set) begin
        overflow <= 1'b1;
      end
    end
  end

  hist_align_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W),
    .HIST_W (HIST_W)
  ) u_align (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .load_x      (cur_x),
    .load_y      (cur_y),
    .load_addr   (cur_addr),
    .load_cb     (Cb_in),
    .load_cr     (Cr_in),
    .ram_rd_data (ram_rd_data),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (color_valid),
    .out_x       (read_x),
    .out_y       (read_y),
    .out_addr    (read_addr),
    .out_cb      (Cb),
    .out_cr      (Cr),
    .out_history (color_history)
  );

endmodule

// File: doc/color_history_fetch.md
Name: color_history_fetch

Overview:
- Read-side companion to the pink-marker corner detector.
- Raster-scans the incoming video stream and issues reads to the 640x480 colour-history RAM.
- Realigns the RAM data with the pixel's Cb/Cr, x, y and address, and presents them to the detector.
- Forwards the detector's own write-backs so a pixel never sees stale history after a read/write collision.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- RD_LAT, 2, RAM read latency in cycles (address registered to data valid); legal range 1..4
- ADDR_W, 19, history RAM address width
- HIST_W, 4, history bits per pixel

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- VGA_VS  in  1  vertical sync, active low; a falling edge starts a frame
- pix_en  in  1  one active pixel presented this cycle
- Cb_in  in  8  pixel chroma blue
- Cr_in  in  8  pixel chroma red
- ram_rd_addr  out  ADDR_W  history RAM read address (registered)
- ram_rd_data  in  HIST_W  RAM data, RD_LAT cycles after ram_rd_addr
- wb_we  in  1  detector write-back enable
- wb_addr  in  ADDR_W  detector write-back address
- wb_data  in  HIST_W  detector write-back data
- Cb  out  8  aligned Cb
- Cr  out  8  aligned Cr
- color_history  out  HIST_W  aligned, forwarded history
- color_valid  out  1  outputs valid this cycle
- read_addr  out  ADDR_W  aligned pixel address
- read_x  out  10  aligned column
- read_y  out  10  aligned row
- frame_start  out  1  one-cycle pulse per detected VS falling edge
- overflow  out  1  sticky; pixels arrived after the frame was complete

Behaviour:
- Reset values: all outputs 0; state WAIT_VS; counters x=y=addr=0; pipeline valid bits cleared; VS_prev=1.
- Frame edge: VS_prev && ~VGA_VS, with VS_prev registered every cycle. It is the only way to reach ACTIVE.
- State WAIT_VS: pix_en ignored, no RAM reads. Frame edge -> ACTIVE, counters cleared, frame_start=1 next cycle.
- State ACTIVE, pix_en=1: accept pixel (x, y, addr).
  - ram_rd_addr<=addr.
  - Stage 0 of the pipeline loads {valid, x, y, addr, Cb_in, Cr_in, fwd=0}.
  - Counters advance: x++; when x==H_ACTIVE-1, x=0 and y++.
  - addr++ (incremental; no multiplier). addr equals y*H_ACTIVE+x at all times.
- Accepting (H_ACTIVE-1, V_ACTIVE-1) -> state DONE.
- State DONE: pix_en sets overflow and is otherwise ignored. Frame edge -> ACTIVE as above, overflow cleared.
- Frame edge in any state (ACTIVE included): counters cleared; frame_start pulses.
  - If pix_en is high in the same cycle, that pixel is accepted as (0,0), addr 0, of the new frame.
- Pipeline: RD_LAT+1 stages. Latency from the accepting pix_en cycle to color_valid is exactly RD_LAT+1 cycles, with all aligned outputs registered.
  - On the final stage: color_history = fwd ? fwd_data : ram_rd_data.
- Forwarding (RAM is read-first on collision):
  - Every cycle, any valid stage, including the entry being loaded, whose addr==wb_addr while wb_we=1 gets fwd=1 and fwd_data=wb_data.
  - The latest write wins.
- In-flight entries drain normally across a frame edge.
- color_valid is 0 in every cycle without a completed entry. Idle pix_en gaps produce bubbles; there is no backpressure.
- Reset mid-operation: pipeline flushed; color_valid=0 from the cycle after reset is sampled; return to WAIT_VS.

Decomposition:
- Shared package constants: H_ACTIVE, V_ACTIVE, ADDR_W, HIST_W.
- State encoding: WAIT_VS=2'd0, ACTIVE=2'd1, DONE=2'd2. The detector's corner codes stay in their existing place.
- One sub-module: hist_align_pipe. It is the RD_LAT+1-deep delay line holding the per-stage forwarding compare and override.
- The top level holds the FSM, raster counters and VS edge detect.

Test Plan:
- Reset, then 10 pix_en pulses with VS held high -> color_valid never 1; ram_rd_addr stays 0; frame_start never pulses.
- VS fall, then pix_en on 3 consecutive cycles; RAM model returns addr[3:0] with RD_LAT=2 -> color_valid on cycles 3,4,5 after the first pix_en; (x,y,addr,history) = (0,0,0,0), (1,0,1,1), (2,0,2,2); Cb/Cr match the inputs.
- Line wrap: 641 consecutive pixels -> 641st output has read_x=0, read_y=1, read_addr=640. Inserting pix_en gaps produces matching output gaps.
- Forwarding: accept addr 5 (RAM holds 4'h5); one cycle later drive wb_we=1, wb_addr=5, wb_data=4'hA -> output for addr 5 shows 4'hA. A write to addr 6 leaves it at 4'h5.
- Frame end: 307200 pixels, then 3 more -> the last valid output has (639,479,307199); overflow=1; no further reads. Next VS fall -> overflow=0, frame_start=1, next pixel at addr 0.
- Reset asserted while 2 entries are in flight -> color_valid=0 throughout. After release, pixels are ignored until a VS falling edge.
